stopwatch_time_counter: RTL and testbench
=========================================

Name: stopwatch_time_counter

Overview:
Timekeeping datapath directly downstream of the stopwatch control FSM. Consumes the FSM's count_enable level and a synchronous clear, divides the system clock down to a 100 Hz centisecond tick, and maintains a BCD MM:SS.CC count (00:00.00 to 99:59.99). Its outputs drive the display digit mux.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency in Hz.
TICK_HZ, 100, count rate in Hz (one centisecond per tick).
DIV (localparam), CLK_FREQ_HZ/TICK_HZ, prescaler terminal count; must be >= 1. Prescaler width is max(1, clog2(DIV)).

Ports:
clk  input  1  system clock; sole clock, all logic on rising edge.
rst  input  1  reset; synchronous, active-high.
count_enable  input  1  level from the control FSM; high means RUNNING.
clear  input  1  synchronous clear, level-sensitive, driven from the FSM reset request.
centi_bcd  output  8  centiseconds, [7:4] tens, [3:0] units, 00-99.
sec_bcd  output  8  seconds, [7:4] tens (0-5), [3:0] units, 00-59.
min_bcd  output  8  minutes, [7:4] tens, [3:0] units, 00-99.
tick  output  1  one-cycle pulse, high in the cycle the count has just advanced.
wrap  output  1  one-cycle pulse, high in the cycle the count has just rolled 99:59.99 -> 00:00.00.

Behaviour:
- Reset: when rst is high at a clock edge, the prescaler, all six BCD digits, tick and wrap all go to 0. rst has priority over everything else.
- Priority, highest first: rst, clear, count_enable.
- clear: at the edge, the prescaler and all digits go to 0 and tick/wrap go to 0. This holds regardless of count_enable and takes effect one cycle after sampling.
- Prescaler runs only while count_enable=1.
  - If prescaler != DIV-1, it increments.
  - If prescaler == DIV-1, it goes to 0 and the count advances by one centisecond in the same edge.
- count_enable=0: the prescaler and digits hold. The fractional tick is preserved across a pause, so resuming does not restart the centisecond.
- tick and wrap are registered and assert in the same cycle the new digit values first appear. Each is exactly one cycle wide. Both are 0 whenever no advance occurred on the previous edge.
- Advance rules, one BCD increment chain:
  - centi units 9 -> 0 carries to centi tens.
  - centi tens 9 -> 0 carries to sec units.
  - sec units 9 -> 0 carries to sec tens.
  - sec tens 5 -> 0 (at 59) carries to min units.
  - min units 9 -> 0 carries to min tens.
  - min tens 9 -> 0 (at 99:59.99) sets wrap and counting continues from 00:00.00.
- Digits never leave their legal range; every digit is always valid BCD.
- DIV == 1: the count advances on every enabled cycle and tick is high on consecutive cycles.
- count_enable deasserting in the same cycle the prescaler is at DIV-1: no advance, prescaler holds at DIV-1, and the advance occurs on the first enabled edge after resume.
- No combinational path from any input to any output.

Test Plan:
1. Reset: with CLK_FREQ_HZ=1000, TICK_HZ=100 (DIV=10), drive rst=1 for 2 cycles with count_enable=1 -> all digits 00, tick=0, wrap=0, and no advance during reset.
2. First tick: with DIV=10, release rst and hold count_enable=1 -> tick=1 exactly 10 cycles after the first enabled edge, centi_bcd=8'h01, and tick is low for the other 9 cycles.
3. Pause/resume: enable for 7 cycles, disable for 25, enable again -> the first tick arrives on the 3rd enabled cycle after resume with centi_bcd=8'h01, and digits are stable during the pause.
4. Carries: with DIV=1, run 100 enabled cycles -> sec_bcd=8'h01, centi_bcd=8'h00. Run to 6000 -> min_bcd=8'h01, sec_bcd=8'h00, centi_bcd=8'h00. At 5999 the value is 00:59.99.
5. Clear priority: mid-count at 00:12.34, assert clear together with count_enable=1 for 1 cycle -> the next cycle shows 00:00.00 with tick=0. After release, the first advance comes DIV enabled cycles later.
6. Wrap: with DIV=1, run 600000 enabled cycles -> at 599999 the value is 99:59.99. On the next cycle the value is 00:00.00 with tick=1 and wrap=1 for exactly one cycle, and the following cycle shows 00:00.01 with wrap=0.

Source files
------------

// File: rtl/stopwatch_time_counter.sv
// stopwatch_time_counter
// Timekeeping datapath for the stopwatch. A prescaler divides the system
// clock down to a centisecond tick, and each tick advances a BCD
// MM:SS.CC count (00:00.00 .. 99:59.99) that wraps back to 00:00.00.
// tick and wrap are registered pulses that line up with the new digits.

module stopwatch_time_counter #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       count_enable,
    input  logic       clear,
    output logic [7:0] centi_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       tick,
    output logic       wrap
);

    localparam int DIV     = CLK_FREQ_HZ / TICK_HZ;
    localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    // One BCD digit of the increment chain. Returns {carry_out, next_digit}.
    // A digit at (or, defensively, above) its last legal value rolls to 0
    // and carries; without a carry in, the digit is returned unchanged.
    function automatic logic [4:0] bcd_step(input logic [3:0] digit,
                                            input logic [3:0] last,
                                            input logic       carry_in);
        logic [4:0] result;
        result = {1'b0, digit};
        if (carry_in) begin
            if (digit >= last) begin
                result = 5'b1_0000;
            end else begin
                result = {1'b0, digit + 4'd1};
            end
        end
        return result;
    endfunction

    logic [PRESC_W-1:0] presc_p1;
    logic [3:0]         centi_lo_p1;
    logic [3:0]         centi_hi_p1;
    logic [3:0]         sec_lo_p1;
    logic [3:0]         sec_hi_p1;
    logic [3:0]         min_lo_p1;
    logic [3:0]         min_hi_p1;
    logic               tick_p1;
    logic               wrap_p1;

    logic               adv_nx;
    logic [5:0]         carry_nx;
    logic [3:0]         centi_lo_nx;
    logic [3:0]         centi_hi_nx;
    logic [3:0]         sec_lo_nx;
    logic [3:0]         sec_hi_nx;
    logic [3:0]         min_lo_nx;
    logic [3:0]         min_hi_nx;

    // Next-count logic: the advance strobe and the ripple of BCD carries.
    always_comb begin
        adv_nx      = count_enable && (presc_p1 == PRESC_LAST);
        carry_nx    = 6'd0;
        centi_lo_nx = centi_lo_p1;
        centi_hi_nx = centi_hi_p1;
        sec_lo_nx   = sec_lo_p1;
        sec_hi_nx   = sec_hi_p1;
        min_lo_nx   = min_lo_p1;
        min_hi_nx   = min_hi_p1;
        {carry_nx[0], centi_lo_nx} = bcd_step(centi_lo_p1, 4'd9, adv_nx);
        {carry_nx[1], centi_hi_nx} = bcd_step(centi_hi_p1, 4'd9, carry_nx[0]);
        {carry_nx[2], sec_lo_nx}   = bcd_step(sec_lo_p1,   4'd9, carry_nx[1]);
        {carry_nx[3], sec_hi_nx}   = bcd_step(sec_hi_p1,   4'd5, carry_nx[2]);
        {carry_nx[4], min_lo_nx}   = bcd_step(min_lo_p1,   4'd9, carry_nx[3]);
        {carry_nx[5], min_hi_nx}   = bcd_step(min_hi_p1,   4'd9, carry_nx[4]);
    end

    // Stage p1: prescaler, digit registers and the aligned tick/wrap pulses.
    // rst and clear have the same effect; rst simply wins by being tested too.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            presc_p1    <= '0;
            centi_lo_p1 <= 4'd0;
            centi_hi_p1 <= 4'd0;
            sec_lo_p1   <= 4'd0;
            sec_hi_p1   <= 4'd0;
            min_lo_p1   <= 4'd0;
            min_hi_p1   <= 4'd0;
            tick_p1     <= 1'b0;
            wrap_p1     <= 1'b0;
        end else begin
            tick_p1 <= adv_nx;
            wrap_p1 <= carry_nx[5];
            // Paused: prescaler keeps its fractional progress.
            if (count_enable) begin
                if (adv_nx) begin
                    presc_p1 <= '0;
                end else begin
                    presc_p1 <= presc_p1 + PRESC_ONE;
                end
            end
            if (adv_nx) begin
                centi_lo_p1 <= centi_lo_nx;
                centi_hi_p1 <= centi_hi_nx;
                sec_lo_p1   <= sec_lo_nx;
                sec_hi_p1   <= sec_hi_nx;
                min_lo_p1   <= min_lo_nx;
                min_hi_p1   <= min_hi_nx;
            end
        end
    end

    assign centi_bcd = {centi_hi_p1, centi_lo_p1};
    assign sec_bcd   = {sec_hi_p1, sec_lo_p1};
    assign min_bcd   = {min_hi_p1, min_lo_p1};
    assign tick      = tick_p1;
    assign wrap      = wrap_p1;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: instance 0 divides by 10, instance 1
// divides by 1. A count-of-centiseconds model predicts every output each
// cycle; directed literal checks pin the model at the interesting points.

module tb_stopwatch_time_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ce  = 2'b11;
    logic [1:0] clr = 2'b00;
    logic [7:0] centi [2];
    logic [7:0] sec   [2];
    logic [7:0] mins  [2];
    logic [1:0] tick;
    logic [1:0] wrap;

    // model state
    int         cnt   [2] = '{0, 0};
    int         frac  [2] = '{0, 0};
    int         div   [2] = '{10, 1};
    logic [1:0] etick = 2'b00;
    logic [1:0] ewrap = 2'b00;
    logic [1:0] ld    = 2'b00;
    int         ldv   [2] = '{0, 0};
    logic [1:0] chk_en = 2'b11;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stopwatch_time_counter #(.CLK_FREQ_HZ(1000), .TICK_HZ(100)) dut_a (
        .clk(clk), .rst(rst), .count_enable(ce[0]), .clear(clr[0]),
        .centi_bcd(centi[0]), .sec_bcd(sec[0]), .min_bcd(mins[0]),
        .tick(tick[0]), .wrap(wrap[0])
    );

    stopwatch_time_counter #(.CLK_FREQ_HZ(100), .TICK_HZ(100)) dut_b (
        .clk(clk), .rst(rst), .count_enable(ce[1]), .clear(clr[1]),
        .centi_bcd(centi[1]), .sec_bcd(sec[1]), .min_bcd(mins[1]),
        .tick(tick[1]), .wrap(wrap[1])
    );

    function automatic logic [7:0] bcd2(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [23:0] exp_time(input int c);
        return {bcd2(c / 6000), bcd2((c / 100) % 60), bcd2(c % 100)};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] tm(input int i);
        return {mins[i], sec[i], centi[i]};
    endfunction

    // behavioural model: total centiseconds plus fractional clock count
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst || clr[i]) begin
                cnt[i] = 0; frac[i] = 0; etick[i] = 1'b0; ewrap[i] = 1'b0;
            end else begin
                etick[i] = 1'b0;
                ewrap[i] = 1'b0;
                if (ld[i]) cnt[i] = ldv[i];
                if (ce[i]) begin
                    if (frac[i] == div[i] - 1) begin
                        frac[i] = 0;
                        etick[i] = 1'b1;
                        if (cnt[i] == 599999) begin
                            cnt[i] = 0;
                            ewrap[i] = 1'b1;
                        end else begin
                            cnt[i] = cnt[i] + 1;
                        end
                    end else begin
                        frac[i] = frac[i] + 1;
                    end
                end
            end
        end
    end

    // per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (chk_en[i]) begin
                check($sformatf("mon%0d_time", i), tm(i), exp_time(cnt[i]));
                check($sformatf("mon%0d_tick", i), {23'd0, tick[i]}, {23'd0, etick[i]});
                check($sformatf("mon%0d_wrap", i), {23'd0, wrap[i]}, {23'd0, ewrap[i]});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held two cycles with counting requested
        cyc();
        cyc();
        check("rst_time_a", tm(0), 24'h000000);
        check("rst_tick_a", {23'd0, tick[0]}, 24'd0);
        check("rst_time_b", tm(1), 24'h000000);
        check("rst_wrap_b", {23'd0, wrap[1]}, 24'd0);

        // first tick after DIV enabled edges
        rst = 1'b0;
        ce  = 2'b01;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i < 10) begin
                check("first_tick_low", {23'd0, tick[0]}, 24'd0);
            end else begin
                check("first_tick_high", {23'd0, tick[0]}, 24'd1);
                check("first_tick_time", tm(0), 24'h000001);
            end
        end
        cyc();
        check("tick_one_wide", {23'd0, tick[0]}, 24'd0);

        // clear, then pause/resume keeps the fractional tick
        clr[0] = 1'b1;
        cyc();
        clr[0] = 1'b0;
        check("clear_time", tm(0), 24'h000000);
        for (int i = 0; i < 7; i++) cyc();
        ce[0] = 1'b0;
        for (int i = 0; i < 25; i++) begin
            cyc();
            check("pause_time", tm(0), 24'h000000);
        end
        ce[0] = 1'b1;
        cyc();
        check("resume_1", {23'd0, tick[0]}, 24'd0);
        cyc();
        check("resume_2", {23'd0, tick[0]}, 24'd0);
        cyc();
        check("resume_3_tick", {23'd0, tick[0]}, 24'd1);
        check("resume_3_time", tm(0), 24'h000001);

        // run to 00:12.34, then clear together with enable
        for (int i = 0; i < 12330; i++) cyc();
        check("mid_time", tm(0), 24'h001234);
        clr[0] = 1'b1;
        cyc();
        clr[0] = 1'b0;
        check("clr_prio_time", tm(0), 24'h000000);
        check("clr_prio_tick", {23'd0, tick[0]}, 24'd0);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i < 10) check("post_clr_low", {23'd0, tick[0]}, 24'd0);
            else check("post_clr_time", tm(0), 24'h000001);
        end
        ce[0] = 1'b0;

        // DIV=1 carries
        ce[1] = 1'b1;
        for (int i = 1; i <= 6000; i++) begin
            cyc();
            if (i == 99)   check("carry_99",   tm(1), 24'h000099);
            if (i == 100)  check("carry_100",  tm(1), 24'h000100);
            if (i == 5999) check("carry_5999", tm(1), 24'h005999);
            if (i == 6000) check("carry_6000", tm(1), 24'h010000);
        end

        // wrap: preload 99:59.97 while paused
        chk_en[1] = 1'b0;
        ce[1]     = 1'b0;
        ld[1]     = 1'b1;
        ldv[1]    = 599997;
        force dut_b.min_hi_p1   = 4'd9;
        force dut_b.min_lo_p1   = 4'd9;
        force dut_b.sec_hi_p1   = 4'd5;
        force dut_b.sec_lo_p1   = 4'd9;
        force dut_b.centi_hi_p1 = 4'd9;
        force dut_b.centi_lo_p1 = 4'd7;
        cyc();
        release dut_b.min_hi_p1;
        release dut_b.min_lo_p1;
        release dut_b.sec_hi_p1;
        release dut_b.sec_lo_p1;
        release dut_b.centi_hi_p1;
        release dut_b.centi_lo_p1;
        ld[1]     = 1'b0;
        chk_en[1] = 1'b1;
        check("preload_time", tm(1), 24'h995997);
        ce[1] = 1'b1;
        cyc();
        check("wrap_98", tm(1), 24'h995998);
        cyc();
        check("wrap_99", tm(1), 24'h995999);
        check("wrap_99_flag", {23'd0, wrap[1]}, 24'd0);
        cyc();
        check("wrap_time", tm(1), 24'h000000);
        check("wrap_tick", {23'd0, tick[1]}, 24'd1);
        check("wrap_flag", {23'd0, wrap[1]}, 24'd1);
        cyc();
        check("after_wrap_time", tm(1), 24'h000001);
        check("after_wrap_flag", {23'd0, wrap[1]}, 24'd0);
        cyc();
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
